// File: rtl/alu_pkg.sv
// alu_pkg: op encodings and the {carry,G} function shared by the ALU core.
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;
  localparam int MAXW = 32;
  // Evaluates at MAXW bits; w selects the live width so carry lands at bit w.
  function automatic logic [MAXW:0] alu_calc(input logic [1:0] s, input logic [MAXW-1:0] a,
                                             input logic [MAXW-1:0] b, input logic [5:0] w);
    logic [MAXW-1:0] m;
    logic [MAXW:0] t;
    m = w >= 6'(MAXW) ? '1 : (MAXW'(1) << w) - MAXW'(1);
    t = s == OP_ADD ? {1'b0, a & m} + {1'b0, b & m}
      : s == OP_SUB ? {1'b0, a & m} + {1'b0, ~b & m} + {{MAXW{1'b0}}, 1'b1}
      : {1'b0, (s == OP_AND ? a & b : a | b) & m};
    return {s[1] ? 1'b0 : t[w], t[MAXW-1:0] & m};
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ADD/SUB/AND/OR with carry; ALU_SAT_EN adds ADD/SUB saturation.
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] g,
  output logic             c
);
  logic [MAXW:0] r;
  logic [WIDTH-1:0] raw;
  logic hi_unused;
  always_comb begin
    r = alu_calc(s, MAXW'(a), MAXW'(b), 6'(WIDTH));
    raw = r[WIDTH-1:0];
    c = r[MAXW];
    hi_unused = ^r[MAXW-1:WIDTH-1];
`ifdef ALU_SAT_EN
    g = s == OP_ADD && c ? '1 : s == OP_SUB && !c ? '0 : raw;
`else
    g = raw;
`endif
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU with accumulate mode around one alu_core.
// Build with ALU_SAT_EN defined for saturating ADD/SUB.
module alu_pipe import alu_pkg::*; #(
  parameter int               WIDTH    = 3,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       S,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] G,
  output logic             carry,
  output logic             zero
);
  logic [WIDTH-1:0] alu_g, acc_q, acc_d, g1_q, g1_d, g_q, g_d;
  logic alu_c, c1_q, c1_d, v1_q, v1_d, c_q, c_d, z_q, z_d, v_q, v_d;
  logic take, adv, load;
  alu_core #(.WIDTH(WIDTH)) u_core (
    .a(A),
    .b(acc_mode ? acc_q : B),
    .s(S),
    .g(alu_g),
    .c(alu_c)
  );
  // Stage 2 moves whenever it is empty or drained, so in_ready depends on out_ready.
  always_comb begin
    adv = !v_q || out_ready;
    in_ready = !v1_q || adv;
    take = in_valid && in_ready;
    load = adv && v1_q;
    v1_d = take || (v1_q && !adv);
    g1_d = take ? alu_g : g1_q;
    c1_d = take ? alu_c : c1_q;
    acc_d = acc_clr ? ACC_INIT : take ? alu_g : acc_q;
    v_d = adv ? v1_q : v_q;
    g_d = load ? g1_q : g_q;
    c_d = load ? c1_q : c_q;
    z_d = load ? g1_q == '0 : z_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= ACC_INIT;
      g1_q <= '0;
      c1_q <= 1'b0;
      v1_q <= 1'b0;
      g_q <= '0;
      c_q <= 1'b0;
      z_q <= 1'b1;
      v_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      g1_q <= g1_d;
      c1_q <= c1_d;
      v1_q <= v1_d;
      g_q <= g_d;
      c_q <= c_d;
      z_q <= z_d;
      v_q <= v_d;
    end
  end
  assign out_valid = v_q;
  assign G = g_q;
  assign carry = c_q;
  assign zero = z_q;
endmodule
